// File: rtl/usb_tx_scheduler_pkg.sv
// Shared PIDs, scheduler state and response encodings for the USB TX scheduler.
package usb_pkg;

    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TURNAROUND,
        ST_SEND_NAK,
        ST_SEND_DATA,
        ST_WAIT_ACK
    } sched_state_t;

    typedef enum logic {
        RESP_NAK,
        RESP_DATA
    } resp_t;

    // DATA PID selected by the current toggle bit (1 = DATA1).
    function automatic logic [3:0] data_pid(input logic toggle);
        return toggle ? PID_DATA1 : PID_DATA0;
    endfunction

endpackage

// File: rtl/usb_tx_scheduler_if.sv
// Token receiver / transmit datapath signals seen by the TX scheduler.
interface usb_tx_scheduler_if;
    logic       rx_token_valid;
    logic [3:0] rx_pid;
    logic       rx_addr_match;
    logic       fifo_ready;
    logic       tx_byte_req;
    logic       tx_done;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic       tx_last;
    logic       fifo_r_enable;
    logic       is_txing;
    logic       data_toggle;

    // Scheduler side.
    modport slave (
        input  rx_token_valid, rx_pid, rx_addr_match, fifo_ready, tx_byte_req, tx_done,
        output tx_start, tx_pid, tx_last, fifo_r_enable, is_txing, data_toggle
    );

    // Receiver / transmitter / FIFO side.
    modport master (
        output rx_token_valid, rx_pid, rx_addr_match, fifo_ready, tx_byte_req, tx_done,
        input  tx_start, tx_pid, tx_last, fifo_r_enable, is_txing, data_toggle
    );
endinterface

// File: rtl/usb_tx_scheduler_flex_counter.sv
// Cycle timer with synchronous clear, count enable and a programmable last value.
module flex_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] rollover_val_i,
    output logic             rollover_flag_o
);

    logic [WIDTH-1:0] count_q, count_d;

    // Clear wins over enable; the count wraps to 0 after the last value.
    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (enable_i)
            count_d = (count_q == rollover_val_i) ? '0 : count_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/usb_tx_scheduler.sv
// Decides whether/what/when the device answers a token, paces payload FIFO
// reads during a data packet and tracks the DATA0/DATA1 toggle.
module usb_tx_scheduler
    import usb_pkg::*;
#(
    parameter int PKT_BYTES       = 64,
    parameter int TURNAROUND_CYC  = 16,   // must be >= 2
    parameter int ACK_TIMEOUT_CYC = 144
) (
    input  logic                clk,
    input  logic                rst,
    usb_tx_scheduler_if.slave   bus
);

    localparam int TMR_W = $clog2((TURNAROUND_CYC > ACK_TIMEOUT_CYC) ? TURNAROUND_CYC
                                                                      : ACK_TIMEOUT_CYC);
    localparam int CNT_W = $clog2(PKT_BYTES + 1);

    localparam logic [TMR_W-1:0] TURN_LAST = TMR_W'(TURNAROUND_CYC - 1);
    localparam logic [TMR_W-1:0] ACK_LAST  = TMR_W'(ACK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(PKT_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PKT_BYTES - 1);

    sched_state_t     state_q;
    resp_t            resp_q;
    logic             tx_start_q;
    logic             is_txing_q;
    logic             data_toggle_q;
    logic [3:0]       tx_pid_q;
    logic [CNT_W-1:0] byte_cnt_q;

    logic             tok_accept;
    logic             pop;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_roll;
    logic [TMR_W-1:0] tmr_last;

    // ACK in IDLE is a stray handshake; everything else addressed to us gets an answer.
    assign tok_accept = bus.rx_token_valid && bus.rx_addr_match && (bus.rx_pid != PID_ACK);

    // Pop is combinational so the FIFO byte is ready in the request cycle.
    assign pop = bus.tx_byte_req && is_txing_q && (state_q == ST_SEND_DATA)
              && (byte_cnt_q < CNT_FULL);

    // Timer control: the token cycle itself is counted so the registered
    // tx_start lands exactly TURNAROUND_CYC cycles after the token.
    always_comb begin
        tmr_clr  = 1'b1;
        tmr_en   = 1'b0;
        tmr_last = ACK_LAST;
        case (state_q)
            ST_IDLE: begin
                tmr_last = TURN_LAST;
                if (tok_accept) begin
                    tmr_clr = 1'b0;
                    tmr_en  = 1'b1;
                end
            end
            ST_TURNAROUND: begin
                tmr_last = TURN_LAST;
                tmr_clr  = 1'b0;
                tmr_en   = 1'b1;
            end
            ST_WAIT_ACK: begin
                tmr_clr = bus.rx_token_valid;
                tmr_en  = 1'b1;
            end
            default: ;
        endcase
    end

    flex_counter #(.WIDTH(TMR_W)) u_timer (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (tmr_clr),
        .enable_i        (tmr_en),
        .rollover_val_i  (tmr_last),
        .rollover_flag_o (tmr_roll)
    );

    // Scheduler FSM with registered outputs and the inline payload byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            resp_q        <= RESP_NAK;
            tx_start_q    <= 1'b0;
            is_txing_q    <= 1'b0;
            data_toggle_q <= 1'b1;
            tx_pid_q      <= PID_NAK;
            byte_cnt_q    <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tok_accept) begin
                        // FIFO readiness is frozen here for the whole packet.
                        resp_q  <= (bus.rx_pid == PID_IN && bus.fifo_ready) ? RESP_DATA
                                                                            : RESP_NAK;
                        state_q <= ST_TURNAROUND;
                    end
                end
                ST_TURNAROUND: begin
                    if (tmr_roll) begin
                        tx_start_q <= 1'b1;
                        is_txing_q <= 1'b1;
                        byte_cnt_q <= '0;
                        if (resp_q == RESP_DATA) begin
                            tx_pid_q <= data_pid(data_toggle_q);
                            state_q  <= ST_SEND_DATA;
                        end else begin
                            tx_pid_q <= PID_NAK;
                            state_q  <= ST_SEND_NAK;
                        end
                    end
                end
                ST_SEND_NAK: begin
                    if (bus.tx_done) begin
                        is_txing_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_SEND_DATA: begin
                    if (pop)
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                    if (bus.tx_done) begin
                        is_txing_q <= 1'b0;
                        state_q    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // Any packet ends the wait; only ACK advances the toggle.
                    if (bus.rx_token_valid) begin
                        if (bus.rx_pid == PID_ACK)
                            data_toggle_q <= ~data_toggle_q;
                        state_q <= ST_IDLE;
                    end else if (tmr_roll) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_start      = tx_start_q;
    assign bus.tx_pid        = tx_pid_q;
    assign bus.tx_last       = (state_q == ST_SEND_DATA) && (byte_cnt_q == CNT_LAST);
    assign bus.fifo_r_enable = pop;
    assign bus.is_txing      = is_txing_q;
    assign bus.data_toggle   = data_toggle_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Randomized transaction-level bench for usb_tx_scheduler with a toggle/response model.
module tb_usb_tx_scheduler;
    import usb_pkg::*;

    localparam int PKT   = 64;
    localparam int TURN  = 16;
    localparam int ACKTO = 144;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_tx_scheduler_if bus();

    usb_tx_scheduler #(
        .PKT_BYTES       (PKT),
        .TURNAROUND_CYC  (TURN),
        .ACK_TIMEOUT_CYC (ACKTO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk = 0;
    int   n_err = 0;
    logic mdl_tog;   // expected toggle: 1 after reset, flips on each ACKed data packet

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tok(input logic [3:0] pid, input logic match);
        bus.rx_token_valid = 1'b1;
        bus.rx_pid         = pid;
        bus.rx_addr_match  = match;
        tick();
        bus.rx_token_valid = 1'b0;
        bus.rx_pid         = 4'h0;
        bus.rx_addr_match  = 1'b0;
    endtask

    // Device must never pop the FIFO while it is not driving the bus.
    always @(negedge clk)
        if (!rst && bus.fifo_r_enable) chk("pop_gate", {31'd0, bus.is_txing}, 32'd1);

    task automatic quiet_check(input string tag, input int cycles);
        logic saw = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.is_txing || bus.tx_start) saw = 1'b1;
        end
        #1;
        chk(tag, {31'd0, saw}, 32'd0);
    endtask

    // Wait for tx_start after a token; returns the cycle offset from the token.
    task automatic wait_start(input bit inject, output int lat);
        lat = 1;
        while (1) begin
            @(negedge clk);
            if (bus.tx_start || lat >= 40) break;
            tick();
            bus.rx_token_valid = 1'b0;
            lat++;
            if (inject && lat == 5) begin
                bus.rx_token_valid = 1'b1;
                bus.rx_pid         = 4'($urandom);
                bus.rx_addr_match  = 1'b1;
            end
        end
        bus.rx_token_valid = 1'b0;
        chk("start_lat", lat, TURN);
    endtask

    // One token plus the complete answer; ack_mode: 0 ACK, 1 other packet, 2 timeout, -1 random.
    task automatic run_txn(input logic [3:0] pid, input logic match, input logic fifo,
                           input int ack_mode);
        bit         resp, data, overlap;
        logic [3:0] exp_pid;
        int         lat, nreq, pops, mode;
        resp    = match && (pid != PID_ACK);
        data    = resp && (pid == PID_IN) && fifo;
        exp_pid = data ? (mdl_tog ? PID_DATA1 : PID_DATA0) : PID_NAK;
        bus.fifo_ready = fifo;
        send_tok(pid, match);
        if (!resp) begin
            quiet_check("ignored_tok", 200);
            return;
        end
        bus.fifo_ready = 1'($urandom);   // must not affect the latched response
        wait_start(1'($urandom), lat);
        if (!bus.tx_start) return;
        chk("tx_pid", {28'd0, bus.tx_pid}, {28'd0, exp_pid});
        chk("txing_rise", {31'd0, bus.is_txing}, 32'd1);
        tick();
        if (!data) begin
            repeat (2) begin
                bus.tx_byte_req = 1'b1;
                @(negedge clk);
                chk("nak_pop", {31'd0, bus.fifo_r_enable}, 32'd0);
                tick();
                bus.tx_byte_req = 1'b0;
            end
            bus.tx_done = 1'b1;
            @(negedge clk);
            chk("txing_done", {31'd0, bus.is_txing}, 32'd1);
            tick();
            bus.tx_done = 1'b0;
            @(negedge clk);
            chk("txing_fall", {31'd0, bus.is_txing}, 32'd0);
            chk("pid_hold", {28'd0, bus.tx_pid}, {28'd0, exp_pid});
            #1;
        end else begin
            overlap = 1'($urandom);
            nreq    = overlap ? PKT : PKT + 1 + $urandom_range(1);
            pops    = 0;
            for (int i = 0; i < nreq; i++) begin
                repeat ($urandom_range(2)) tick();
                bus.tx_byte_req = 1'b1;
                if (overlap && i == nreq - 1) bus.tx_done = 1'b1;
                @(negedge clk);
                chk("pop", {31'd0, bus.fifo_r_enable}, (i < PKT) ? 32'd1 : 32'd0);
                chk("last", {31'd0, bus.tx_last}, (i == PKT - 1) ? 32'd1 : 32'd0);
                if (bus.fifo_r_enable) pops++;
                if (bus.tx_done) chk("txing_done", {31'd0, bus.is_txing}, 32'd1);
                tick();
                bus.tx_byte_req = 1'b0;
                bus.tx_done     = 1'b0;
            end
            if (!overlap) begin
                bus.tx_done = 1'b1;
                @(negedge clk);
                chk("txing_done", {31'd0, bus.is_txing}, 32'd1);
                tick();
                bus.tx_done = 1'b0;
            end
            @(negedge clk);
            chk("txing_fall", {31'd0, bus.is_txing}, 32'd0);
            chk("pops", pops, PKT);
            chk("pid_hold", {28'd0, bus.tx_pid}, {28'd0, exp_pid});
            #1;
            mode = (ack_mode < 0) ? int'($urandom_range(2)) : ack_mode;
            if (mode == 0) begin
                repeat ($urandom_range(100)) tick();
                send_tok(PID_ACK, 1'($urandom));
                mdl_tog = ~mdl_tog;
            end else if (mode == 1) begin
                repeat ($urandom_range(100)) tick();
                bus.fifo_ready = 1'b1;
                send_tok(PID_IN, 1'b1);
                quiet_check("dropped_pkt", 40);
            end else begin
                repeat (ACKTO + 10) tick();
            end
        end
        repeat (3) tick();
        chk("toggle", {31'd0, bus.data_toggle}, {31'd0, mdl_tog});
    endtask

    // Reset pulsed while payload bytes are being requested.
    task automatic rst_mid();
        int lat;
        bus.fifo_ready = 1'b1;
        send_tok(PID_IN, 1'b1);
        wait_start(1'b0, lat);
        tick();
        repeat (5) begin
            bus.tx_byte_req = 1'b1;
            tick();
            bus.tx_byte_req = 1'b0;
        end
        bus.tx_byte_req = 1'b1;
        #1;
        chk("pre_rst_pop", {31'd0, bus.fifo_r_enable}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_txing", {31'd0, bus.is_txing}, 32'd0);
        chk("rst_pop", {31'd0, bus.fifo_r_enable}, 32'd0);
        chk("rst_toggle", {31'd0, bus.data_toggle}, 32'd1);
        tick();
        bus.tx_byte_req = 1'b0;
        rst     = 1'b0;
        mdl_tog = 1'b1;
        tick();
    endtask

    initial begin
        bus.rx_token_valid = 1'b0;
        bus.rx_pid         = 4'h0;
        bus.rx_addr_match  = 1'b0;
        bus.fifo_ready     = 1'b0;
        bus.tx_byte_req    = 1'b0;
        bus.tx_done        = 1'b0;
        mdl_tog            = 1'b1;
        repeat (3) tick();
        chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
        chk("rst_tx_pid", {28'd0, bus.tx_pid}, {28'd0, PID_NAK});
        chk("rst_tx_last", {31'd0, bus.tx_last}, 32'd0);
        chk("rst_pop0", {31'd0, bus.fifo_r_enable}, 32'd0);
        chk("rst_txing0", {31'd0, bus.is_txing}, 32'd0);
        chk("rst_toggle0", {31'd0, bus.data_toggle}, 32'd1);
        rst = 1'b0;
        repeat (2) tick();

        run_txn(PID_IN, 1'b1, 1'b0, 0);      // NAK, FIFO empty
        run_txn(PID_IN, 1'b1, 1'b1, 0);      // DATA1 then ACK
        run_txn(PID_IN, 1'b1, 1'b1, 2);      // DATA0, ACK timeout
        run_txn(PID_IN, 1'b1, 1'b1, 1);      // DATA0 repeated, other packet ends wait
        run_txn(4'b1100, 1'b1, 1'b1, 0);     // non-IN token -> NAK
        run_txn(PID_IN, 1'b0, 1'b1, 0);      // not our address
        run_txn(PID_ACK, 1'b1, 1'b1, 0);     // stray ACK in IDLE
        rst_mid();
        run_txn(PID_IN, 1'b1, 1'b1, 0);      // DATA1 after reset

        for (int k = 0; k < 20; k++) begin
            logic [3:0] p;
            p = ($urandom_range(3) != 0) ? PID_IN : 4'($urandom);
            run_txn(p, ($urandom_range(4) != 0), 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
